// File: rtl/f_pc_npc_ctrl.sv
// -----------------------------------------------------------------------------
// f_pc_npc_ctrl
//
// Fetch-side program counter and IF/ID pipeline register.
//   - Holds the fetch PC and forms the next PC from four sources:
//     sequential (f_pc + 4), conditional branch, j/jal and jr/jalr.
//   - Branch decisions come in already resolved by the D-stage comparator flags.
//   - There is one architectural delay slot. On the edge that applies a
//     redirect, the instruction at f_pc (= d_pc + 4) still enters IF/ID, and
//     it is never flushed.
//   - Flags a sticky fetch address error whenever a misaligned address is
//     loaded into the PC.
//
// Parameters
//   PC_RESET   PC value after reset, which is also the first fetch address.
//   INSTR_NOP  IF/ID instruction value after reset.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous, active-low reset
//   stall       hold the PC and IF/ID this cycle (hazard unit)
//   im_instr    instruction word read at f_pc (combinational IM)
//   d_branch    D instruction is a conditional branch
//   d_br_type   branch kind: 0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez,
//               6-7 never taken
//   d_equ       rs_val == rt_val
//   d_ltz       rs_val < 0
//   d_eqz       rs_val == 0
//   d_jump      D instruction is j/jal
//   d_jr        D instruction is jr/jalr
//   d_rs_val    forwarded rs value (jr target)
//   f_pc        current fetch address
//   d_instr     IF/ID instruction
//   d_pc        IF/ID PC
//   d_pc8       d_pc + 8 (link address)
//   d_taken     D control transfer redirects the NPC this cycle
//   f_adel      sticky misaligned-fetch flag
// -----------------------------------------------------------------------------
module f_pc_npc_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] im_instr,
  input  logic        d_branch,
  input  logic [2:0]  d_br_type,
  input  logic        d_equ,
  input  logic        d_ltz,
  input  logic        d_eqz,
  input  logic        d_jump,
  input  logic        d_jr,
  input  logic [31:0] d_rs_val,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_taken,
  output logic        f_adel
);

  // Branch type encodings
  localparam logic [2:0] BrBeq  = 3'd0;
  localparam logic [2:0] BrBne  = 3'd1;
  localparam logic [2:0] BrBlez = 3'd2;
  localparam logic [2:0] BrBgtz = 3'd3;
  localparam logic [2:0] BrBltz = 3'd4;
  localparam logic [2:0] BrBgez = 3'd5;

  // Architectural state
  logic [31:0] r_f_pc;
  logic [31:0] r_d_instr;
  logic [31:0] r_d_pc;
  logic        r_f_adel;

  // Next-PC datapath
  logic [31:0] w_f_pc4;
  logic [31:0] w_d_pc4;
  logic [15:0] w_imm;
  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic        w_br_cond;
  logic        w_br_taken;
  logic [31:0] w_npc;

  assign w_f_pc4  = r_f_pc + 32'd4;
  assign w_d_pc4  = r_d_pc + 32'd4;
  assign w_imm    = r_d_instr[15:0];
  assign w_br_off = {{14{w_imm[15]}}, w_imm, 2'b00};
  assign w_br_tgt = w_d_pc4 + w_br_off;

  // The region bits come from the delay-slot address, not from d_pc itself,
  // so a jump sitting in the last word of a 256 MB region lands in the next one.
  assign w_j_tgt  = {w_d_pc4[31:28], r_d_instr[25:0], 2'b00};

  // Branch condition, decoded from the comparator flags
  always_comb begin
    w_br_cond = 1'b0;
    unique case (d_br_type)
      BrBeq:   w_br_cond = d_equ;
      BrBne:   w_br_cond = ~d_equ;
      BrBlez:  w_br_cond = d_ltz | d_eqz;
      BrBgtz:  w_br_cond = ~d_ltz & ~d_eqz;
      BrBltz:  w_br_cond = d_ltz;
      BrBgez:  w_br_cond = ~d_ltz;
      default: w_br_cond = 1'b0;
    endcase
  end

  assign w_br_taken = d_branch & w_br_cond;

  // The decoder never raises two sources at once. The priority order only
  // keeps the result deterministic if it ever does.
  always_comb begin
    w_npc = w_f_pc4;
    if (d_jr) begin
      w_npc = d_rs_val;
    end else if (d_jump) begin
      w_npc = w_j_tgt;
    end else if (w_br_taken) begin
      w_npc = w_br_tgt;
    end
  end

  // PC register and sticky address-error flag. While stalled, the redirect
  // request is simply not sampled. It takes effect on the first unstalled
  // edge, using whatever flags are present then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f_pc   <= PC_RESET;
      r_f_adel <= 1'b0;
    end else if (!stall) begin
      r_f_pc <= w_npc;
      if (w_npc[1:0] != 2'b00) begin
        r_f_adel <= 1'b1;
      end
    end
  end

  // IF/ID register. There is no flush: the delay-slot instruction always
  // enters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d_instr <= INSTR_NOP;
      r_d_pc    <= PC_RESET;
    end else if (!stall) begin
      r_d_instr <= im_instr;
      r_d_pc    <= r_f_pc;
    end
  end

  assign f_pc    = r_f_pc;
  assign d_instr = r_d_instr;
  assign d_pc    = r_d_pc;
  assign d_pc8   = r_d_pc + 32'd8;
  assign d_taken = w_br_taken | d_jump | d_jr;
  assign f_adel  = r_f_adel;

endmodule
